mem_arbiter: RTL and testbench

Sequencing controller that shares the single unified main-memory port between the instruction-cache and data-cache miss paths of the pipelined processor. Accepts one outstanding fill/write-back request from each cache, picks a winner, drives the memory for a fixed access latency, and returns data with a one-cycle done pulse. Sits between the two cache controllers and the four-bank memory model. It also keeps per-requester grant counters for the perf summary.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_lat_cnt.sv | 34 +++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I-cache/D-cache main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  localparam int unsigned MEM_LAT_DEF = 4;
  localparam int unsigned GNT_CNT_W   = 16;
  localparam logic [GNT_CNT_W-1:0] GNT_CNT_SAT = 16'hFFFF;

  // Grant counters stick at full scale instead of wrapping.
  function automatic logic [GNT_CNT_W-1:0] sat_inc(input logic [GNT_CNT_W-1:0] v);
    return (v == GNT_CNT_SAT) ? v : v + GNT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing the memory access latency; last_c flags a count of one.
module mem_arb_lat_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c = (cnt_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache and D-cache miss paths.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the D-cache wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ic_req,
  input  logic [ADDR_W-1:0]    ic_addr,
  output logic                 ic_done,
  output logic [DATA_W-1:0]    ic_rdata,
  input  logic                 dc_req,
  input  logic                 dc_wr,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [DATA_W-1:0]    dc_wdata,
  output logic                 dc_done,
  output logic [DATA_W-1:0]    dc_rdata,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_stall,
  output logic [GNT_CNT_W-1:0] ic_grant_cnt,
  output logic [GNT_CNT_W-1:0] dc_grant_cnt
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  state_e                state_q, state_d;
  req_id_e               id_q, id_d, win_c;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  mem_en_q, mem_en_d;
  logic                  ic_done_q, ic_done_d, dc_done_q, dc_done_d;
  logic [DATA_W-1:0]     ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic [GNT_CNT_W-1:0]  ic_grant_cnt_q, ic_grant_cnt_d, dc_grant_cnt_q, dc_grant_cnt_d;
  logic                  cnt_load_c, cnt_dec_c, cnt_last_c;
`ifdef MEM_ARB_RR_EN
  req_id_e               last_q, last_d;
`endif

  // Winner selection; only differs between builds when both requesters are present.
  always_comb begin
    win_c = dc_req ? REQ_DC : REQ_IC;
`ifdef MEM_ARB_RR_EN
    if (ic_req && dc_req) begin
      win_c = (last_q == REQ_DC) ? REQ_IC : REQ_DC;
    end
`endif
  end

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_en_d       = 1'b0;
    ic_done_d      = 1'b0;
    dc_done_d      = 1'b0;
    ic_rdata_d     = ic_rdata_q;
    dc_rdata_d     = dc_rdata_q;
    ic_grant_cnt_d = ic_grant_cnt_q;
    dc_grant_cnt_d = dc_grant_cnt_q;
    cnt_load_c     = 1'b0;
    cnt_dec_c      = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d         = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          id_d     = win_c;
          addr_d   = (win_c == REQ_DC) ? dc_addr : ic_addr;
          wr_d     = (win_c == REQ_DC) && dc_wr;
          wdata_d  = (win_c == REQ_DC) ? dc_wdata : '0;
          if (win_c == REQ_DC) begin
            dc_grant_cnt_d = sat_inc(dc_grant_cnt_q);
          end else begin
            ic_grant_cnt_d = sat_inc(ic_grant_cnt_q);
          end
`ifdef MEM_ARB_RR_EN
          last_d   = win_c;
`endif
          mem_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_stall) begin
          mem_en_d = 1'b1;
        end else begin
          cnt_load_c = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_dec_c = 1'b1;
        if (cnt_last_c) begin
          // Writes return zero rather than whatever the bus carries.
          if (id_q == REQ_DC) begin
            dc_rdata_d = wr_q ? '0 : mem_rdata;
            dc_done_d  = 1'b1;
          end else begin
            ic_rdata_d = mem_rdata;
            ic_done_d  = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      id_q           <= REQ_IC;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      mem_en_q       <= 1'b0;
      ic_done_q      <= 1'b0;
      dc_done_q      <= 1'b0;
      ic_rdata_q     <= '0;
      dc_rdata_q     <= '0;
      ic_grant_cnt_q <= '0;
      dc_grant_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      mem_en_q       <= mem_en_d;
      ic_done_q      <= ic_done_d;
      dc_done_q      <= dc_done_d;
      ic_rdata_q     <= ic_rdata_d;
      dc_rdata_q     <= dc_rdata_d;
      ic_grant_cnt_q <= ic_grant_cnt_d;
      dc_grant_cnt_q <= dc_grant_cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Pointer starts at D-cache so the first tie after reset goes to the I-cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_DC;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  mem_arb_lat_cnt #(
    .W(CNT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load_c),
    .load_val(CNT_W'(MEM_LAT)),
    .dec     (cnt_dec_c),
    .last_c  (cnt_last_c)
  );

  assign mem_en       = mem_en_q;
  assign mem_wr       = wr_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign ic_done      = ic_done_q;
  assign dc_done      = dc_done_q;
  assign ic_rdata     = ic_rdata_q;
  assign dc_rdata     = dc_rdata_q;
  assign ic_grant_cnt = ic_grant_cnt_q;
  assign dc_grant_cnt = dc_grant_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req, dc_req, dc_wr;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          ic_done, dc_done, mem_en, mem_wr;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_stall = 1'b0;
  logic [15:0]   ic_grant_cnt, dc_grant_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h1274;
  endfunction

  // Memory model: stalls on request, returns read data exactly LAT cycles after acceptance.
  logic [15:0] phys_mem [logic [15:0]];
  int          stall_req  = 0;
  int          stall_used = 0;
  int          countdown  = 0;
  logic [15:0] pend_data  = '0;

  always @(negedge clk) begin
    mem_stall = 1'b0;
    mem_rdata = ~pend_data;
    if (countdown > 0) begin
      countdown = countdown - 1;
      if (countdown == 0) mem_rdata = pend_data;
    end
    if (!rst_n) begin
      stall_used = 0;
      countdown  = 0;
    end else if (mem_en) begin
      if (stall_used < stall_req) begin
        mem_stall  = 1'b1;
        stall_used = stall_used + 1;
      end else begin
        stall_used = 0;
        if (mem_wr) begin
          phys_mem[mem_addr] = mem_wdata;
        end else begin
          pend_data = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr);
          countdown = LAT;
        end
      end
    end
  end

  // Reference model state
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] m_ic, m_dc;
`ifdef MEM_ARB_RR_EN
  logic        m_last;
`endif

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 1 = D-cache wins
  function automatic logic pick(input logic ir, input logic dr);
`ifdef MEM_ARB_RR_EN
    if (ir && dr) return ~m_last;
`endif
    return dr || !ir;
  endfunction

  task automatic model_reset();
    m_ic = '0;
    m_dc = '0;
`ifdef MEM_ARB_RR_EN
    m_last = 1'b1;
`endif
  endtask

  task automatic model_grant(input logic w);
    if (w) m_dc = sat16(m_dc);
    else   m_ic = sat16(m_ic);
`ifdef MEM_ARB_RR_EN
    m_last = w;
`endif
  endtask

  typedef struct {
    int          cyc;
    logic        got_ic;
    logic        got_dc;
    logic        both;
    logic        timeout;
    logic [15:0] ic_rd;
    logic [15:0] dc_rd;
    int          en_cyc;
    logic [15:0] en_addr;
    logic        en_wr;
    logic [15:0] en_wdata;
    logic        unstable;
  } obs_t;

  // Observes the DUT one negedge at a time until a done pulse or the budget runs out.
  task automatic wait_done(input int budget, output obs_t o);
    o.cyc = 0; o.got_ic = 0; o.got_dc = 0; o.both = 0; o.timeout = 0;
    o.ic_rd = '0; o.dc_rd = '0; o.en_cyc = 0; o.en_addr = '0; o.en_wr = 0;
    o.en_wdata = '0; o.unstable = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      o.cyc++;
      if (mem_en) begin
        if (o.en_cyc == 0) begin
          o.en_addr = mem_addr; o.en_wr = mem_wr; o.en_wdata = mem_wdata;
        end else if (mem_addr !== o.en_addr || mem_wr !== o.en_wr || mem_wdata !== o.en_wdata) begin
          o.unstable = 1;
        end
        o.en_cyc++;
      end
      if (ic_done && dc_done) o.both = 1;
      if (ic_done || dc_done) begin
        o.got_ic = ic_done; o.got_dc = dc_done; o.ic_rd = ic_rdata; o.dc_rd = dc_rdata;
        break;
      end
      if (i == budget - 1) o.timeout = 1;
    end
  endtask

  // Each requester holds req for pi/pd transactions in a row; entered and left in IDLE.
  task automatic run_batch(input int pi0, input int pd0, output logic [15:0] seq, output int n);
    int          pi, pd, stalls, exp_lat;
    logic [15:0] ia, da, dwd, exp_rd, got_rd;
    logic        dw, w;
    obs_t        o;
    pi = pi0; pd = pd0; seq = '0; n = 0;
    ia  = 16'h0200 + 16'($urandom_range(0, 7));
    da  = 16'h0200 + 16'($urandom_range(0, 7));
    dw  = 1'($urandom_range(0, 1));
    dwd = 16'($urandom);
    while (pi + pd > 0) begin
      ic_req = (pi > 0); ic_addr = ia;
      dc_req = (pd > 0); dc_addr = da; dc_wr = dw; dc_wdata = dwd;
      w = pick(ic_req, dc_req);
      model_grant(w);
      stalls    = $urandom_range(0, 2);
      stall_req = stalls;
      exp_lat   = ((n == 0) ? LAT + 2 : LAT + 3) + stalls;
      exp_rd    = w ? (dw ? 16'h0000 : ref_rd(da)) : ref_rd(ia);
      wait_done(40, o);
      tests_run++;
      if (o.timeout) begin
        tests_failed++;
        $display("FAIL batch_timeout: no done within 40 cycles (txn %0d)", n);
        break;
      end
      tests_run++;
      if ({o.got_ic, o.got_dc} !== {~w, w}) begin
        tests_failed++;
        $display("FAIL batch_winner: got ic=%b dc=%b exp dc_wins=%b (txn %0d)", o.got_ic, o.got_dc, w, n);
      end
      tests_run++;
      if (o.cyc !== exp_lat) begin
        tests_failed++;
        $display("FAIL batch_latency: got %0d exp %0d (txn %0d)", o.cyc, exp_lat, n);
      end
      got_rd = w ? o.dc_rd : o.ic_rd;
      tests_run++;
      if (got_rd !== exp_rd) begin
        tests_failed++;
        $display("FAIL batch_rdata: got %h exp %h (txn %0d)", got_rd, exp_rd, n);
      end
      tests_run++;
      if (o.en_cyc !== stalls + 1 || o.unstable || o.en_addr !== (w ? da : ia) || o.en_wr !== (w && dw)) begin
        tests_failed++;
        $display("FAIL batch_mem_if: got en=%0d addr=%h wr=%b unstable=%b exp en=%0d addr=%h wr=%b",
                 o.en_cyc, o.en_addr, o.en_wr, o.unstable, stalls + 1, w ? da : ia, w && dw);
      end
      if (w && dw) begin
        tests_run++;
        if (o.en_wdata !== dwd) begin
          tests_failed++;
          $display("FAIL batch_wdata: got %h exp %h", o.en_wdata, dwd);
        end
      end
      tests_run++;
      if ({ic_grant_cnt, dc_grant_cnt} !== {m_ic, m_dc} || o.both) begin
        tests_failed++;
        $display("FAIL batch_counts: got ic=%h dc=%h both=%b exp ic=%h dc=%h",
                 ic_grant_cnt, dc_grant_cnt, o.both, m_ic, m_dc);
      end
      seq = {seq[14:0], w};
      n++;
      if (w) begin
        if (dw) ref_mem[da] = dwd;
        pd--;
        da  = 16'h0200 + 16'($urandom_range(0, 7));
        dw  = 1'($urandom_range(0, 1));
        dwd = 16'($urandom);
      end else begin
        pi--;
        ia = 16'h0200 + 16'($urandom_range(0, 7));
      end
    end
    ic_req = 0; dc_req = 0; stall_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({ic_done, dc_done, mem_en, mem_wr, mem_addr, mem_wdata, ic_rdata, dc_rdata,
         ic_grant_cnt, dc_grant_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b addr=%h cnt=%h/%h exp all zero", mem_en, mem_addr, ic_grant_cnt, dc_grant_cnt);
    end
    rst_n = 1;
    model_reset();
    @(negedge clk);
    tests_run++;
    if ({ic_done, dc_done, mem_en} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_idle: got done=%b%b en=%b exp 000", ic_done, dc_done, mem_en);
    end
  endtask

  task automatic test_single_read();
    obs_t o;
    ic_addr = 16'h0040; ic_req = 1;
    wait_done(20, o);
    model_grant(1'b0);
    ic_req = 0;
    tests_run++;
    if (o.cyc !== 6 || o.got_ic !== 1'b1) begin
      tests_failed++;
      $display("FAIL ic_read_latency: got cyc=%0d ic_done=%b exp cyc=6 ic_done=1", o.cyc, o.got_ic);
    end
    tests_run++;
    if (o.ic_rd !== 16'h1234) begin
      tests_failed++;
      $display("FAIL ic_read_data: got %h exp 1234", o.ic_rd);
    end
    tests_run++;
    if (ic_grant_cnt !== 16'd1 || o.got_dc !== 1'b0) begin
      tests_failed++;
      $display("FAIL ic_read_cnt: got cnt=%h dc_done=%b exp cnt=0001 dc_done=0", ic_grant_cnt, o.got_dc);
    end
    tests_run++;
    if (o.en_cyc !== 1 || o.en_addr !== 16'h0040 || o.en_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ic_read_mem: got en=%0d addr=%h wr=%b exp 1 0040 0", o.en_cyc, o.en_addr, o.en_wr);
    end
    @(negedge clk);
    tests_run++;
    if (ic_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ic_done_pulse: got %b exp 0 one cycle after done", ic_done);
    end
  endtask

  task automatic test_dc_write();
    obs_t o;
    dc_addr = 16'h0100; dc_wr = 1; dc_wdata = 16'hBEEF; dc_req = 1;
    wait_done(20, o);
    model_grant(1'b1);
    ref_mem[16'h0100] = 16'hBEEF;
    dc_req = 0;
    tests_run++;
    if (o.en_cyc !== 1 || o.en_wr !== 1'b1 || o.en_addr !== 16'h0100 || o.en_wdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL dc_write_mem: got en=%0d wr=%b addr=%h wdata=%h exp 1 1 0100 beef",
               o.en_cyc, o.en_wr, o.en_addr, o.en_wdata);
    end
    tests_run++;
    if (o.cyc !== 6 || o.got_dc !== 1'b1 || o.dc_rd !== 16'h0000 || dc_grant_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL dc_write_done: got cyc=%0d done=%b rdata=%h cnt=%h exp 6 1 0000 0001",
               o.cyc, o.got_dc, o.dc_rd, dc_grant_cnt);
    end
    @(negedge clk);
    dc_wr = 0; dc_req = 1;
    wait_done(20, o);
    model_grant(1'b1);
    dc_req = 0;
    tests_run++;
    if (o.cyc !== 6 || o.dc_rd !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL dc_readback: got cyc=%0d rdata=%h exp 6 beef", o.cyc, o.dc_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_tie();
    logic [15:0] seq;
    logic [4:0]  exp_seq;
    int          n;
`ifdef MEM_ARB_RR_EN
    exp_seq = 5'b01011;
`else
    exp_seq = 5'b11100;
`endif
    run_batch(2, 3, seq, n);
    tests_run++;
    if (n !== 5 || seq[4:0] !== exp_seq) begin
      tests_failed++;
      $display("FAIL tie_order: got n=%0d seq=%b exp n=5 seq=%b (1=D)", n, seq[4:0], exp_seq);
    end
  endtask

  task automatic test_stall();
    obs_t o;
    ic_addr = 16'h0300; ic_req = 1; stall_req = 3;
    wait_done(30, o);
    model_grant(1'b0);
    ic_req = 0; stall_req = 0;
    tests_run++;
    if (o.en_cyc !== 4 || o.unstable !== 1'b0 || o.en_addr !== 16'h0300) begin
      tests_failed++;
      $display("FAIL stall_hold: got en=%0d unstable=%b addr=%h exp 4 0 0300", o.en_cyc, o.unstable, o.en_addr);
    end
    tests_run++;
    if (o.cyc !== 9 || o.ic_rd !== ref_rd(16'h0300)) begin
      tests_failed++;
      $display("FAIL stall_done: got cyc=%0d rdata=%h exp 9 %h", o.cyc, o.ic_rd, ref_rd(16'h0300));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] seq;
    int          n;
    for (int r = 0; r < 6; r++) begin
      run_batch($urandom_range(0, 3), $urandom_range(1, 3), seq, n);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   spurious;
    dc_addr = 16'h0080; dc_wr = 0; dc_req = 1;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    tests_run++;
    if ({ic_done, dc_done, mem_en, mem_wr, mem_addr, mem_wdata, ic_rdata, dc_rdata,
         ic_grant_cnt, dc_grant_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got rdata=%h/%h cnt=%h/%h exp all zero", ic_rdata, dc_rdata, ic_grant_cnt, dc_grant_cnt);
    end
    @(negedge clk);
    dc_req = 0; rst_n = 1;
    model_reset();
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (ic_done || dc_done) spurious++;
    end
    tests_run++;
    if (spurious !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d done pulses exp 0", spurious);
    end
    dc_req = 1;
    wait_done(20, o);
    model_grant(1'b1);
    dc_req = 0;
    tests_run++;
    if (o.cyc !== 6 || o.got_dc !== 1'b1 || o.dc_rd !== ref_rd(16'h0080)) begin
      tests_failed++;
      $display("FAIL midreset_next: got cyc=%0d done=%b rdata=%h exp 6 1 %h", o.cyc, o.got_dc, o.dc_rd, ref_rd(16'h0080));
    end
    tests_run++;
    if ({ic_grant_cnt, dc_grant_cnt} !== {m_ic, m_dc}) begin
      tests_failed++;
      $display("FAIL midreset_cnt: got %h/%h exp %h/%h", ic_grant_cnt, dc_grant_cnt, m_ic, m_dc);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    logic [15:0] seq;
    int          n;
    force dut.dc_grant_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.dc_grant_cnt_q;
    m_dc = 16'hFFFE;
    run_batch(0, 3, seq, n);
    tests_run++;
    if (dc_grant_cnt !== 16'hFFFF || n !== 3) begin
      tests_failed++;
      $display("FAIL saturate: got cnt=%h n=%0d exp ffff 3", dc_grant_cnt, n);
    end
  endtask

  initial begin
    rst_n = 0; ic_req = 0; dc_req = 0; dc_wr = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_dc_write();
    test_back_to_back_tie();
    test_stall();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule
